// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer, serialises one byte per frame on s_tick timing.
// Ports: clk, reset (sync, active-high), tx_start (send request, IDLE only),
//        s_tick (16x oversampling tick), din[7:0] (byte, [DBIT-1:0] used),
//        tx_busy (frame in flight), tx_done_tick (end-of-stop pulse), tx (registered line).
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);
    localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic p, p_n;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t     state, state_n;
    logic [4:0] s, s_n;
    logic [2:0] n, n_n;
    logic [7:0] b, b_n;
    logic       tx_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            p     <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
            tx    <= tx_n;
`ifdef UART_TX_PARITY_EN
            p     <= p_n;
`endif
        end
    end
    // tx_n is the line value for the cycle after the edge, so tx changes
    // exactly on the edge that changes state.
    always_comb begin
        state_n      = state;
        s_n          = s;
        n_n          = n;
        b_n          = b;
        tx_n         = tx;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        p_n          = p;
`endif
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (tx_start) begin
                    state_n = START;
                    s_n     = '0;
                    b_n     = din;
                    tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    p_n     = ^din[DBIT-1:0];
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_n     = '0;
                        state_n = DATA;
                        tx_n    = b[0];
                    end else s_n = s + 5'd1;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == N_LAST) begin
                            n_n = '0;
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
                            tx_n    = p;
`else
                            state_n = STOP;
                            tx_n    = 1'b1;
`endif
                        end else begin
                            n_n  = n + 3'd1;
                            tx_n = b[1];
                        end
                    end else s_n = s + 5'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_n     = '0;
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else s_n = s + 5'd1;
                end
            end
`endif
            STOP: begin
                tx_n = 1'b1;
                if (s_tick) begin
                    if (s == S_LAST) begin
                        tx_done_tick = 1'b1;
                        s_n          = '0;
                        state_n      = IDLE;
                    end else s_n = s + 5'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end
    assign tx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized self-checking bench for uart_tx_ctrl against a tick-count frame model.
module tb_uart_tx_ctrl;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + DBIT + PB;
    localparam int TOTAL = NBITS * 16 + SB_TICK;

    logic       clk = 0, reset = 0, tx_start = 0, s_tick = 0;
    logic [7:0] din = '0;
    logic       tx_busy, tx_done_tick, tx;

    uart_tx_ctrl #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
        .din(din), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    bit known = 0, active = 0;
    int k = 0, ph = 0, done_seen = 0, frames_exp = 0;
    bit fb[NBITS];

    task automatic chk(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b k=%0d t=%0t", tag, got, exp, k, $time);
        end
    endtask

    task automatic chk_i(input string tag, input int got, input int exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line value k ticks into the frame: bit k/16 of the frame, then stop-level high.
    function automatic logic exp_tx();
        if (!active) return 1'b1;
        return (k / 16 < NBITS) ? fb[k / 16] : 1'b1;
    endfunction

    task automatic step(input logic r, input logic st, input logic tk, input logic [7:0] dv);
        reset = r; tx_start = st; s_tick = tk; din = dv;
        #1;
        if (known) begin
            chk("tx", tx, exp_tx());
            chk("busy", tx_busy, active);
            chk("done", tx_done_tick, active && tk && (k == TOTAL - 1));
        end
        if (tx_done_tick === 1'b1) done_seen++;
        @(posedge clk);
        if (r) begin
            known  = 1;
            active = 0;
        end else if (!active) begin
            if (st) begin
                active = 1;
                k      = 0;
                fb[0]  = 1'b0;
                for (int i = 0; i < DBIT; i++) fb[1 + i] = dv[i];
                if (PB == 1) fb[NBITS - 1] = ^(dv & 8'((1 << DBIT) - 1));
            end
        end else if (tk) begin
            k++;
            if (k == TOTAL) begin
                active = 0;
                frames_exp++;
            end
        end
        #1;
    endtask

    task automatic tstep(input logic r, input logic st, input logic [7:0] dv, input int gap);
        logic tk;
        tk = ((ph % gap) == 0);
        ph++;
        step(r, st, tk, dv);
    endtask

    // spam: 0 none, 1 at tick 40 and in the done cycle, 2 also random requests.
    task automatic run(input logic [7:0] dv, input int gap, input int spam,
                       input int gate_at, input int rst_at, input int exp_done);
        int budget, d0, f0;
        logic tk, st;
        d0 = done_seen;
        f0 = frames_exp;
        tstep(0, 1, dv, gap);
        budget = TOTAL * gap + 400;
        while (active && budget > 0) begin
            budget--;
            if (gate_at >= 0 && k == gate_at) begin
                repeat (100) step(0, 0, 0, ~dv);
                gate_at = -1;
            end else if (rst_at >= 0 && k == rst_at) begin
                step(1, 0, 0, 8'h00);
                rst_at = -1;
            end else begin
                tk = ((ph % gap) == 0);
                ph++;
                st = (spam > 0) && ((k == 40) || (tk && k == TOTAL - 1) ||
                                    (spam == 2 && $urandom_range(0, 7) == 0));
                step(0, st, tk, st ? 8'hFF : 8'($urandom));
            end
        end
        chk_i("frame_timeout", (budget > 0) ? 1 : 0, 1);
        repeat (6) tstep(0, 0, 8'h00, gap);
        chk_i("done_count", done_seen - d0, exp_done);
        chk_i("model_frames", frames_exp - f0, exp_done);
    endtask

    initial begin
        repeat (3) tstep(1, 0, 8'h00, 4);
        repeat (20) tstep(0, 0, 8'h00, 4);
        run(8'hA5, 4, 0, -1, -1, 1);
        run(8'h3C, 4, 1, -1, -1, 1);
        run(8'h5A, 4, 0, 50, -1, 1);
        run(8'h00, 4, 0, -1, 69, 0);
        run(8'h81, 4, 0, -1, -1, 1);
        run(8'h07, 4, 0, -1, -1, 1);
        run(8'h03, 4, 0, -1, -1, 1);
        for (int i = 0; i < 6; i++)
            run(8'($urandom), int'($urandom_range(1, 5)), 2,
                (i % 2 == 0) ? int'($urandom_range(16, 140)) : -1, -1, 1);
        repeat (10) tstep(0, 0, 8'h00, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
